// File: rtl/collector_n_if.sv
// Source-side and sink-side stream bundle for collector_n.
// The slave modport is the collector's own view; master is the surrounding environment.
interface collector_n_if #(
  parameter int CHANNELS = 4,
  parameter int WIDTH    = 32,
  parameter int SELW     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
);
  logic [CHANNELS-1:0]       iValid_AS;
  logic [CHANNELS-1:0]       oReady_AS;
  logic [CHANNELS*WIDTH-1:0] iData_AS;
  logic [CHANNELS-1:0]       iLast_AS;
  logic                      oValid_BM;
  logic                      iReady_BM;
  logic [SELW-1:0]           oSelect_BM;
  logic [WIDTH-1:0]          oData_BM;
  logic                      oLast_BM;

  modport slave (
    input  iValid_AS, iData_AS, iLast_AS, iReady_BM,
    output oReady_AS, oValid_BM, oSelect_BM, oData_BM, oLast_BM
  );

  modport master (
    output iValid_AS, iData_AS, iLast_AS, iReady_BM,
    input  oReady_AS, oValid_BM, oSelect_BM, oData_BM, oLast_BM
  );
endinterface

// File: rtl/collector_n.sv
// N-input stream collector: arbitrates valid/ready sources onto one registered sink,
// with fixed-priority or round-robin grant and optional packet locking on last.
module collector_n #(
  parameter int CHANNELS = 4,
  parameter int WIDTH    = 32,
  parameter int MODE     = 0,
  parameter int PRIORITY = 0,
  parameter int LOCK     = 0
) (
  input  logic          iCLK,
  input  logic          iRST,
  collector_n_if.slave  bus
);
  localparam int SELW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  typedef enum logic {ST_IDLE, ST_LOCKED} lock_state_e;

  lock_state_e         state_q, state_d;
  logic [SELW-1:0]     lk_q, lk_d;
  logic [SELW-1:0]     rr_q, rr_d;

  logic                val_q;
  logic [SELW-1:0]     sel_q;
  logic [WIDTH-1:0]    data_q;
  logic                last_q;

  logic [SELW-1:0]     start;
  logic [SELW-1:0]     gnt;
  logic                found;
  int unsigned         idx;
  logic                wacc;
  logic                xfer;
  logic [CHANNELS-1:0] rdy;
  logic [WIDTH-1:0]    gnt_data;
  logic                gnt_last;

  // Circular scan from the start index; an active lock overrides the scan result.
  always_comb begin
    gnt   = '0;
    found = 1'b0;
    idx   = 0;
    start = (MODE != 0) ? rr_q : SELW'(PRIORITY);
    for (int unsigned i = 0; i < CHANNELS; i++) begin
      idx = 32'(start) + i;
      if (idx >= CHANNELS) idx = idx - CHANNELS;
      if (!found && bus.iValid_AS[idx]) begin
        found = 1'b1;
        gnt   = SELW'(idx);
      end
    end
    if (LOCK != 0 && state_q == ST_LOCKED) gnt = lk_q;
  end

  always_comb begin
    wacc     = !val_q || bus.iReady_BM;
    rdy      = '0;
    gnt_data = '0;
    gnt_last = 1'b0;
    for (int unsigned k = 0; k < CHANNELS; k++) begin
      if (SELW'(k) == gnt) begin
        gnt_data = bus.iData_AS[k*WIDTH +: WIDTH];
        gnt_last = bus.iLast_AS[k];
        rdy[k]   = wacc && bus.iValid_AS[k] && !iRST;
      end
    end
    xfer = |rdy;
  end

  always_comb begin
    state_d = state_q;
    lk_d    = lk_q;
    rr_d    = rr_q;
    if (xfer) begin
      if (LOCK == 0 || gnt_last)
        rr_d = (32'(gnt) + 32'd1 == CHANNELS) ? '0 : gnt + 1'b1;
      if (LOCK != 0) begin
        state_d = gnt_last ? ST_IDLE : ST_LOCKED;
        lk_d    = gnt;
      end
    end
  end

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      state_q <= ST_IDLE;
      lk_q    <= '0;
      rr_q    <= '0;
      val_q   <= 1'b0;
      sel_q   <= '0;
      data_q  <= '0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      lk_q    <= lk_d;
      rr_q    <= rr_d;
      if (xfer) begin
        val_q  <= 1'b1;
        sel_q  <= gnt;
        data_q <= gnt_data;
        last_q <= gnt_last;
      end else if (wacc) begin
        val_q  <= 1'b0;
      end
    end
  end

  assign bus.oReady_AS  = rdy;
  assign bus.oValid_BM  = val_q;
  assign bus.oSelect_BM = sel_q;
  assign bus.oData_BM   = data_q;
  assign bus.oLast_BM   = last_q;
endmodule

// File: tb/tb_collector_n.sv
// Directed bench for collector_n: fixed priority, round-robin, backpressure,
// idle drain, packet locking and reset mid-packet, each on its own instance.
module tb_collector_n;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  collector_n_if #(.CHANNELS(4), .WIDTH(8)) if_f0 ();
  collector_n_if #(.CHANNELS(4), .WIDTH(8)) if_f2 ();
  collector_n_if #(.CHANNELS(4), .WIDTH(8)) if_rr ();
  collector_n_if #(.CHANNELS(4), .WIDTH(8)) if_lk ();

  collector_n #(.CHANNELS(4), .WIDTH(8), .MODE(0), .PRIORITY(0), .LOCK(0))
    u_f0 (.iCLK(clk), .iRST(rst), .bus(if_f0));
  collector_n #(.CHANNELS(4), .WIDTH(8), .MODE(0), .PRIORITY(2), .LOCK(0))
    u_f2 (.iCLK(clk), .iRST(rst), .bus(if_f2));
  collector_n #(.CHANNELS(4), .WIDTH(8), .MODE(1), .PRIORITY(0), .LOCK(0))
    u_rr (.iCLK(clk), .iRST(rst), .bus(if_rr));
  collector_n #(.CHANNELS(4), .WIDTH(8), .MODE(1), .PRIORITY(0), .LOCK(1))
    u_lk (.iCLK(clk), .iRST(rst), .bus(if_lk));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int sel;
    rst = 1'b1;
    if_f0.iValid_AS = 4'hF; if_f0.iData_AS = {8'h13, 8'h12, 8'h11, 8'h10};
    if_f0.iLast_AS  = '0;   if_f0.iReady_BM = 1'b1;
    if_f2.iValid_AS = 4'hF; if_f2.iData_AS = {8'h13, 8'h12, 8'h11, 8'h10};
    if_f2.iLast_AS  = '0;   if_f2.iReady_BM = 1'b1;
    if_rr.iValid_AS = 4'hF; if_rr.iData_AS = {8'h23, 8'h22, 8'h21, 8'h20};
    if_rr.iLast_AS  = '0;   if_rr.iReady_BM = 1'b1;
    if_lk.iValid_AS = '0;   if_lk.iData_AS = {8'h00, 8'h00, 8'h41, 8'h30};
    if_lk.iLast_AS  = '0;   if_lk.iReady_BM = 1'b1;

    // Reset state
    #1 chk("rst_ready_f0", 32'(if_f0.oReady_AS), 32'h0);
    tick(); tick();
    chk("rst_valid", 32'(if_f0.oValid_BM), 32'h0);
    chk("rst_sel",   32'(if_f0.oSelect_BM), 32'h0);
    chk("rst_data",  32'(if_f0.oData_BM), 32'h0);
    chk("rst_last",  32'(if_f0.oLast_BM), 32'h0);
    chk("rst_valid_rr", 32'(if_rr.oValid_BM), 32'h0);

    // Fixed priority (0 and 2) and round-robin, all channels valid
    rst = 1'b0;
    #1 chk("f0_ready", 32'(if_f0.oReady_AS), 32'h1);
    chk("f2_ready", 32'(if_f2.oReady_AS), 32'h4);
    for (int c = 0; c < 5; c++) begin
      tick();
      chk("f0_sel",   32'(if_f0.oSelect_BM), 32'h0);
      chk("f0_data",  32'(if_f0.oData_BM), 32'h10);
      chk("f2_sel",   32'(if_f2.oSelect_BM), 32'h2);
      chk("f2_data",  32'(if_f2.oData_BM), 32'h12);
      chk("rr_valid", 32'(if_rr.oValid_BM), 32'h1);
      chk("rr_sel",   32'(if_rr.oSelect_BM), 32'(c % 4));
      chk("rr_data",  32'(if_rr.oData_BM), 32'h20 + 32'(c % 4));
    end

    // Priority wrap: order 2,3,0,1 with only 0,1 valid picks 0
    if_f2.iValid_AS = 4'b0011;
    if_f0.iValid_AS = 4'b0000;
    #1 chk("f2_wrap_ready", 32'(if_f2.oReady_AS), 32'h1);
    chk("f0_idle_ready", 32'(if_f0.oReady_AS), 32'h0);

    // Round-robin over channels 1 and 3
    if_rr.iValid_AS = 4'b1010;
    for (int c = 0; c < 4; c++) begin
      tick();
      sel = (c % 2 == 0) ? 1 : 3;
      chk("rr13_sel",  32'(if_rr.oSelect_BM), 32'(sel));
      chk("rr13_data", 32'(if_rr.oData_BM), 32'h20 + 32'(sel));
    end
    chk("f2_wrap_sel",  32'(if_f2.oSelect_BM), 32'h0);
    chk("f2_wrap_data", 32'(if_f2.oData_BM), 32'h10);
    if_f2.iValid_AS = '0;

    // Backpressure on channel 2
    if_rr.iValid_AS = 4'b0100;
    if_rr.iData_AS  = {8'h23, 8'hA5, 8'h21, 8'h20};
    tick();
    chk("bp_first_sel",  32'(if_rr.oSelect_BM), 32'h2);
    chk("bp_first_data", 32'(if_rr.oData_BM), 32'hA5);
    if_rr.iReady_BM = 1'b0;
    if_rr.iData_AS[23:16] = 8'hA6;
    for (int c = 0; c < 5; c++) begin
      #1 chk("bp_ready", 32'(if_rr.oReady_AS), 32'h0);
      tick();
      chk("bp_valid", 32'(if_rr.oValid_BM), 32'h1);
      chk("bp_sel",   32'(if_rr.oSelect_BM), 32'h2);
      chk("bp_data",  32'(if_rr.oData_BM), 32'hA5);
    end
    if_rr.iReady_BM = 1'b1;
    #1 chk("bp_release_ready", 32'(if_rr.oReady_AS), 32'h4);
    tick();
    chk("bp_next_valid", 32'(if_rr.oValid_BM), 32'h1);
    chk("bp_next_data",  32'(if_rr.oData_BM), 32'hA6);
    if_rr.iValid_AS = '0;
    tick();
    chk("drain_valid", 32'(if_rr.oValid_BM), 32'h0);

    // Idle
    for (int c = 0; c < 10; c++) begin
      #1 chk("idle_ready", 32'(if_rr.oReady_AS), 32'h0);
      tick();
      chk("idle_valid", 32'(if_rr.oValid_BM), 32'h0);
    end

    // Lock: single-beat packet on ch0 moves the pointer to 1
    if_lk.iValid_AS = 4'b0001; if_lk.iLast_AS = 4'b0001;
    tick();
    chk("lk_single_sel",  32'(if_lk.oSelect_BM), 32'h0);
    chk("lk_single_last", 32'(if_lk.oLast_BM), 32'h1);
    if_lk.iValid_AS = 4'b0011;
    #1 chk("lk_b1_ready", 32'(if_lk.oReady_AS), 32'h2);
    tick();
    chk("lk_b1_sel",  32'(if_lk.oSelect_BM), 32'h1);
    chk("lk_b1_data", 32'(if_lk.oData_BM), 32'h41);
    chk("lk_b1_last", 32'(if_lk.oLast_BM), 32'h0);
    if_lk.iValid_AS = 4'b0001;
    #1 chk("lk_hold_ready", 32'(if_lk.oReady_AS), 32'h0);
    tick();
    chk("lk_hold_valid", 32'(if_lk.oValid_BM), 32'h0);
    if_lk.iValid_AS = 4'b0011; if_lk.iData_AS[15:8] = 8'h42;
    #1 chk("lk_b2_ready", 32'(if_lk.oReady_AS), 32'h2);
    tick();
    chk("lk_b2_sel",  32'(if_lk.oSelect_BM), 32'h1);
    chk("lk_b2_data", 32'(if_lk.oData_BM), 32'h42);
    if_lk.iData_AS[15:8] = 8'h43; if_lk.iLast_AS = 4'b0011;
    tick();
    chk("lk_b3_sel",  32'(if_lk.oSelect_BM), 32'h1);
    chk("lk_b3_data", 32'(if_lk.oData_BM), 32'h43);
    chk("lk_b3_last", 32'(if_lk.oLast_BM), 32'h1);
    if_lk.iLast_AS = 4'b0001;
    #1 chk("lk_after_ready", 32'(if_lk.oReady_AS), 32'h1);
    tick();
    chk("lk_after_sel",  32'(if_lk.oSelect_BM), 32'h0);
    chk("lk_after_data", 32'(if_lk.oData_BM), 32'h30);
    if_lk.iData_AS[15:8] = 8'h51;
    #1 chk("lk_ptr_ready", 32'(if_lk.oReady_AS), 32'h2);
    tick();
    chk("lk_ptr_sel", 32'(if_lk.oSelect_BM), 32'h1);

    // Reset while LOCKED(1) with a held beat
    rst = 1'b1;
    #1 chk("lk_rst_ready", 32'(if_lk.oReady_AS), 32'h0);
    tick();
    chk("lk_rst_valid", 32'(if_lk.oValid_BM), 32'h0);
    rst = 1'b0;
    #1 chk("lk_post_ready", 32'(if_lk.oReady_AS), 32'h1);
    tick();
    chk("lk_post_valid", 32'(if_lk.oValid_BM), 32'h1);
    chk("lk_post_sel",   32'(if_lk.oSelect_BM), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/collector_n.md
# collector_n

N-input stream collector that arbitrates several valid/ready source channels onto one registered valid/ready sink. It is the parametrised successor of the two-input collector. It adds:
- a configurable channel count and data width;
- fixed-priority or round-robin arbitration;
- optional packet locking on a per-beat last flag;
- a full-throughput output register.

It sits wherever multiple producer streams must merge into a single consumer and the consumer must know the originating channel.

## Interface
- CHANNELS, 4: number of source channels, ≥1.
- WIDTH, 32: data width per channel.
- MODE, 0: 0 = fixed priority, 1 = round-robin.
- PRIORITY, 0: in MODE 0, the index of the highest-priority channel. Priority descends with increasing index modulo CHANNELS.
- LOCK, 0: 1 = once a channel wins, the grant is held until that channel's beat with last=1 transfers.
- SELW, derived: max(1, ceil(log2(CHANNELS))).

Ports:
- iCLK  input  1  clock; one clock, all logic on rising edge.
- iRST  input  1  reset, synchronous, active-high.
- iValid_AS  input  CHANNELS  per-channel valid.
- oReady_AS  output  CHANNELS  per-channel ready, one-hot or zero.
- iData_AS  input  CHANNELS*WIDTH  channel k occupies bits [k*WIDTH +: WIDTH].
- iLast_AS  input  CHANNELS  per-channel last-beat flag. Ignored when LOCK=0, but still forwarded.
- oValid_BM  output  1  sink valid.
- iReady_BM  input  1  sink ready.
- oSelect_BM  output  SELW  index of the channel that produced the held beat.
- oData_BM  output  WIDTH  held beat data.
- oLast_BM  output  1  held beat last flag.

## Operation
**Output register**
- One output register holds {valid, select, data, last}.
- wacc = !oValid_BM || iReady_BM: the register can accept a beat this cycle.

**Grant**
- The combinational grant picks one channel among those with iValid_AS set.
- Fixed mode: scan starts at PRIORITY.
- Round-robin mode: scan starts at pointer rr.
- Lock: when LOCK=1 and lock state is active, the grant is forced to the locked channel lk. Other channels are never granted, even if lk is not valid.

**Ready**
- oReady_AS[g] = wacc && iValid_AS[g] for granted channel g. All other bits are 0.
- All bits are 0 when no channel is valid.

**Transfer**
- Occurs when oReady_AS[g] && iValid_AS[g] (equivalently oReady_AS[g]).
- On transfer, the register loads valid=1, select=g, data=channel g data, last=iLast_AS[g].
- If wacc holds and there is no transfer, the register clears its valid bit. oData_BM is don't-care but holds its previous value.

**Round-robin pointer**
- On each transfer, rr <= (g+1) mod CHANNELS.
- With LOCK=1, the pointer advances only on a transfer with last=1.

**Lock state machine (LOCK=1 only)**
- States: IDLE and LOCKED(lk).
- IDLE -> LOCKED(g) on a transfer with last=0.
- LOCKED -> IDLE on a transfer with last=1.
- A transfer with last=1 in IDLE stays in IDLE (single-beat packet).

**Reset**
- oValid_BM=0, oSelect_BM=0, oData_BM=0, oLast_BM=0, rr=0, lock=IDLE.
- Reset mid-packet discards the held beat and releases the lock.
- oReady_AS is 0 during the reset cycle.

**Degenerate cases**
- CHANNELS=1: oSelect_BM is a constant 0, and the block degenerates to a pipeline register.

## Timing
- Latency: 1 cycle from input transfer to oValid_BM.
- Throughput: one beat per cycle while iReady_BM=1.
- Combinational paths: iReady_BM -> oReady_AS and iValid_AS -> oReady_AS. There is no path from input to oValid_BM or oData_BM.
- Sink stall: while oValid_BM=1 and iReady_BM=0, oValid_BM, oSelect_BM, oData_BM and oLast_BM stay stable and oReady_AS is 0.
- Simultaneous drain and fill in the same cycle: the new beat replaces the drained one with no bubble.
- Sources may change data while not ready; no beat is lost or duplicated.

## Test plan
- Fixed priority, MODE=0, PRIORITY=0, CHANNELS=4, all valid, iReady_BM=1 -> channel 0 wins every cycle, oSelect_BM=0. With PRIORITY=2 and all valid -> oSelect_BM=2.
- Round-robin, MODE=1, all four channels continuously valid, sink always ready -> oSelect_BM sequence 0,1,2,3,0,… starting one cycle after reset release. With only channels 1 and 3 valid -> sequence 1,3,1,3.
- Backpressure: iReady_BM=0 for 5 cycles with channel 2 data 0xA5 held -> oData_BM=0xA5 stable, oReady_AS=0, no source beat consumed. Release -> the next beat follows with no bubble.
- Lock, LOCK=1, MODE=1: channel 1 sends a 3-beat packet (last on beat 3) while channel 0 is valid throughout -> three consecutive oSelect_BM=1 beats, then channel 0, then the pointer is at 1.
- Reset mid-packet: assert iRST with LOCKED(1) and oValid_BM=1 -> next cycle oValid_BM=0, lock=IDLE, rr=0. After release with channels 0 and 1 valid -> channel 0 is granted first.
- Idle: all iValid_AS=0 for 10 cycles -> oReady_AS=0 and oValid_BM drops one cycle after the last beat drains.
